// File: rtl/oloca_pipe.sv
// oloca_pipe: two-stage pipelined OLOCA approximate adder with a valid/ready
// stream interface and a built-in error monitor. The lower k bits of the sum
// are the OR of the operands; the upper part is added exactly, with an
// optional predicted carry taken from bit k-1. Saturating statistics count
// delivered results, erroneous results and the accumulated absolute error.
module oloca_pipe #(
   parameter int  WIDTH      = 16,
   parameter int  MAX_APPROX = 8,
   parameter int  CNT_W      = 16,
   parameter int  ERR_W      = 24,
   localparam int KW         = $clog2(MAX_APPROX + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [KW-1:0]    approx_k,
   input  logic             carry_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sum,
   output logic             err_flag,
   input  logic             clr_stats,
   output logic [CNT_W-1:0] sample_count,
   output logic [CNT_W-1:0] err_count,
   output logic [ERR_W-1:0] abs_err_sum
);

   // Stage 1: captured operands, clamped depth and carry mode.
   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [KW-1:0]    s1_k;
   logic             s1_mode;

   // Stage 2: result plus the absolute error that feeds the monitor.
   logic             s2_valid;
   logic [WIDTH:0]   abs_err;

   // Handshake and flow-control terms.
   logic s2_adv;
   logic accept;
   logic deliver;
   logic [KW-1:0] k_clamped;

   // Stage-1 combinational results.
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] kbit;
   logic             pred_carry;
   logic [WIDTH:0]   upper;
   logic [WIDTH:0]   approx;
   logic [WIDTH:0]   exact;
   logic [WIDTH:0]   abs_c;

   // Statistics next-value terms.
   logic [ERR_W:0]   acc_next;

   assign s2_adv    = !s2_valid || out_ready;
   assign in_ready  = !s1_valid || s2_adv;
   assign accept    = in_valid && in_ready;
   assign out_valid = s2_valid;
   assign deliver   = s2_valid && out_ready;
   assign k_clamped = (approx_k > KW'(MAX_APPROX)) ? KW'(MAX_APPROX) : approx_k;

   // Approximate sum, exact sum and their absolute difference for the beat in S1.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      kbit       = '0;
      mask       = (WIDTH'(1) << s1_k) - WIDTH'(1);
      if (s1_k != '0) begin
         kbit = WIDTH'(1) << (s1_k - KW'(1));
      end
      pred_carry = s1_mode && ((s1_a & s1_b & kbit) != '0);
      // Upper operands have their low k bits cleared, so the carry lands at bit k.
      upper  = {1'b0, s1_a & ~mask} + {1'b0, s1_b & ~mask}
             + ({{WIDTH{1'b0}}, pred_carry} << s1_k);
      approx = upper | {1'b0, (s1_a | s1_b) & mask};
      exact  = {1'b0, s1_a} + {1'b0, s1_b};
      if (exact >= approx) begin
         abs_c = exact - approx;
      end else begin
         abs_c = approx - exact;
      end
   end

   // Valid bits of both stages; only these need the reset to flush the pipe.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (in_ready) s1_valid <= in_valid;
         if (s2_adv)   s2_valid <= s1_valid;
      end
   end

   // Stage-1 payload capture on an input handshake.
   always_ff @(posedge clk) begin
      // NOTE: payload flops carry no reset; the valid bit says whether they mean anything.
      if (accept) begin
         s1_a    <= a;
         s1_b    <= b;
         s1_k    <= k_clamped;
         s1_mode <= carry_mode;
      end
   end

   // Stage-2 result registers; they hold while the output is stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum      <= '0;
         err_flag <= 1'b0;
         abs_err  <= '0;
      end else if (s2_adv && s1_valid) begin
         sum      <= approx;
         err_flag <= (abs_c != '0);
         abs_err  <= abs_c;
      end
   end

   assign acc_next = {1'b0, abs_err_sum} + (ERR_W+1)'(abs_err);

   // Saturating statistics, updated on output handshakes; clear has priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_count <= '0;
         err_count    <= '0;
         abs_err_sum  <= '0;
      end else if (clr_stats) begin
         sample_count <= '0;
         err_count    <= '0;
         abs_err_sum  <= '0;
      end else if (deliver) begin
         if (sample_count != '1)            sample_count <= sample_count + CNT_W'(1);
         if (err_flag && err_count != '1)   err_count    <= err_count + CNT_W'(1);
         abs_err_sum <= acc_next[ERR_W] ? '1 : acc_next[ERR_W-1:0];
      end
   end

endmodule

// File: tb/tb_oloca_pipe.sv
// Directed and random testbench for oloca_pipe (WIDTH=16, MAX_APPROX=8).
// A second instance with narrow counters shares the stimulus to exercise
// counter saturation.
module tb_oloca_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, out_ready, carry_mode, clr_stats;
   logic [15:0] a, b;
   logic [3:0]  approx_k;
   logic        in_ready, out_valid, err_flag;
   logic [16:0] sum;
   logic [15:0] sample_count, err_count;
   logic [23:0] abs_err_sum;

   logic        s_in_ready, s_out_valid, s_err_flag;
   logic [16:0] s_sum;
   logic [3:0]  s_sample_count, s_err_count;
   logic [5:0]  s_abs_err_sum;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   oloca_pipe #(.WIDTH(16), .MAX_APPROX(8), .CNT_W(16), .ERR_W(24)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .approx_k(approx_k), .carry_mode(carry_mode),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .err_flag(err_flag),
      .clr_stats(clr_stats), .sample_count(sample_count), .err_count(err_count),
      .abs_err_sum(abs_err_sum)
   );

   oloca_pipe #(.WIDTH(16), .MAX_APPROX(8), .CNT_W(4), .ERR_W(6)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
      .a(a), .b(b), .approx_k(approx_k), .carry_mode(carry_mode),
      .out_valid(s_out_valid), .out_ready(out_ready), .sum(s_sum), .err_flag(s_err_flag),
      .clr_stats(clr_stats), .sample_count(s_sample_count), .err_count(s_err_count),
      .abs_err_sum(s_abs_err_sum)
   );

   // Reference: low k bits OR'ed, upper bits added with optional predicted carry.
   function automatic logic [16:0] ref_sum(input logic [15:0] ra, input logic [15:0] rb,
                                           input int k, input logic m);
      logic [16:0] r;
      int          kk;
      logic        c;
      kk = (k > 8) ? 8 : k;
      if (kk == 0) return {1'b0, ra} + {1'b0, rb};
      c = m & ra[kk-1] & rb[kk-1];
      r = (({1'b0, ra} >> kk) + ({1'b0, rb} >> kk) + {16'd0, c}) << kk;
      for (int i = 0; i < kk; i++) r[i] = ra[i] | rb[i];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b1; clr_stats = 1'b0;
      a = '0; b = '0; approx_k = '0; carry_mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      tests++; if (sum !== 17'h0) begin fails++; $display("FAIL reset_sum: got %h expected 0", sum); end
      tests++; if (err_flag !== 1'b0) begin fails++; $display("FAIL reset_err_flag: got %b expected 0", err_flag); end
      tests++; if (sample_count !== 16'd0 || err_count !== 16'd0 || abs_err_sum !== 24'd0) begin
         fails++; $display("FAIL reset_stats: got %0d/%0d/%0d expected 0/0/0", sample_count, err_count, abs_err_sum);
      end
      tests++; if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
         fails++; $display("FAIL reset_sat_inst: got valid=%b ready=%b expected 0/1", s_out_valid, s_in_ready);
      end
      rst = 1'b0;
      tick();
      tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++; $display("FAIL post_reset_idle: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
      end
   endtask

   // One isolated beat with out_ready high: checks latency 2 and the result.
   task automatic run_single(input string nm, input logic [15:0] va, input logic [15:0] vb,
                             input logic [3:0] vk, input logic vm,
                             input logic [16:0] exp_sum, input logic exp_err);
      out_ready = 1'b1;
      in_valid = 1'b1; a = va; b = vb; approx_k = vk; carry_mode = vm;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL %s_in_ready: got %b expected 1", nm, in_ready); end
      tick();
      in_valid = 1'b0;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL %s_early: got out_valid=%b expected 0", nm, out_valid); end
      tick();
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL %s_latency: got out_valid=%b expected 1", nm, out_valid); end
      tests++; if (sum !== exp_sum) begin fails++; $display("FAIL %s_sum: got %h expected %h", nm, sum, exp_sum); end
      tests++; if (err_flag !== exp_err) begin fails++; $display("FAIL %s_err_flag: got %b expected %b", nm, err_flag, exp_err); end
      tick();
   endtask

   task automatic test_operation();
      run_single("or_low",   16'h00FF, 16'h0001, 4'd4, 1'b0, 17'h000FF, 1'b1);
      run_single("carry_m1", 16'h0008, 16'h0008, 4'd4, 1'b1, 17'h00018, 1'b1);
      run_single("carry_m0", 16'h0008, 16'h0008, 4'd4, 1'b0, 17'h00008, 1'b1);
      run_single("exact_k0", 16'hFFFF, 16'h0001, 4'd0, 1'b0, 17'h10000, 1'b0);
      tests++; if (sample_count !== 16'd4 || err_count !== 16'd3 || abs_err_sum !== 24'd17) begin
         fails++; $display("FAIL stats_four: got %0d/%0d/%0d expected 4/3/17", sample_count, err_count, abs_err_sum);
      end
      // k=12 must clamp to 8: 0x0F00+0x0100 is then exact (0x1000), not 0x0F00.
      run_single("clamp_k12", 16'h0F00, 16'h0100, 4'd12, 1'b0, 17'h01000, 1'b0);
      tests++; if (sample_count !== 16'd5 || err_count !== 16'd3 || abs_err_sum !== 24'd17) begin
         fails++; $display("FAIL stats_five: got %0d/%0d/%0d expected 5/3/17", sample_count, err_count, abs_err_sum);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid = 1'b1; a = 16'h0001; b = 16'h0002; approx_k = 4'd0; carry_mode = 1'b0;
      tick();
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_second_ready: got %b expected 1", in_ready); end
      a = 16'h000F; b = 16'h0001; approx_k = 4'd2;
      tick();
      a = 16'h1234; b = 16'h4321; approx_k = 4'd0;
      for (int i = 0; i < 3; i++) begin
         tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready: got %b expected 0", in_ready); end
         tests++; if (out_valid !== 1'b1 || sum !== 17'h00003) begin
            fails++; $display("FAIL bp_hold: got valid=%b sum=%h expected 1/00003", out_valid, sum);
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
      tick();
      in_valid = 1'b0;
      tests++; if (out_valid !== 1'b1 || sum !== 17'h0000F || err_flag !== 1'b1) begin
         fails++; $display("FAIL bp_second_out: got valid=%b sum=%h err=%b expected 1/0000F/1", out_valid, sum, err_flag);
      end
      tick();
      tests++; if (out_valid !== 1'b1 || sum !== 17'h05555) begin
         fails++; $display("FAIL bp_third_out: got valid=%b sum=%h expected 1/05555", out_valid, sum);
      end
      tick();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drained: got out_valid=%b expected 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] va [4];
      logic [15:0] vb [4];
      logic [16:0] ve [4];
      va = '{16'h1000, 16'h2222, 16'hFFFF, 16'h8000};
      vb = '{16'h0001, 16'h1111, 16'hFFFF, 16'h8000};
      ve = '{17'h01001, 17'h03333, 17'h1FFFE, 17'h10000};
      out_ready = 1'b1; approx_k = 4'd0; carry_mode = 1'b0;
      for (int j = 0; j < 6; j++) begin
         if (j < 4) begin
            in_valid = 1'b1; a = va[j]; b = vb[j];
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_%0d: got %b expected 1", j, in_ready); end
         end else begin
            in_valid = 1'b0;
         end
         tick();
         if (j >= 1 && j <= 4) begin
            tests++; if (out_valid !== 1'b1 || sum !== ve[j-1]) begin
               fails++; $display("FAIL b2b_out_%0d: got valid=%b sum=%h expected 1/%h", j - 1, out_valid, sum, ve[j-1]);
            end
         end
      end
   endtask

   task automatic test_clr_stats();
      out_ready = 1'b1;
      in_valid = 1'b1; a = 16'h0001; b = 16'h0001; approx_k = 4'd0; carry_mode = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      tests++; if (out_valid !== 1'b1 || sample_count === 16'd0) begin
         fails++; $display("FAIL clr_setup: got valid=%b count=%0d expected 1/nonzero", out_valid, sample_count);
      end
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      tests++; if (sample_count !== 16'd0 || err_count !== 16'd0 || abs_err_sum !== 24'd0) begin
         fails++; $display("FAIL clr_zero: got %0d/%0d/%0d expected 0/0/0", sample_count, err_count, abs_err_sum);
      end
      tick();
      tests++; if (sample_count !== 16'd0 || out_valid !== 1'b0) begin
         fails++; $display("FAIL clr_not_counted: got count=%0d valid=%b expected 0/0", sample_count, out_valid);
      end
   endtask

   task automatic test_saturation();
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      out_ready = 1'b1;
      in_valid = 1'b1; a = 16'h0008; b = 16'h0008; approx_k = 4'd4; carry_mode = 1'b0;
      repeat (17) tick();
      in_valid = 1'b0;
      repeat (3) tick();
      tests++; if (sample_count !== 16'd17 || err_count !== 16'd17 || abs_err_sum !== 24'd136) begin
         fails++; $display("FAIL sat_wide: got %0d/%0d/%0d expected 17/17/136", sample_count, err_count, abs_err_sum);
      end
      tests++; if (s_sample_count !== 4'd15 || s_err_count !== 4'd15 || s_abs_err_sum !== 6'd63) begin
         fails++; $display("FAIL sat_narrow: got %0d/%0d/%0d expected 15/15/63", s_sample_count, s_err_count, s_abs_err_sum);
      end
      tests++; if (s_sum !== 17'h00008 || s_err_flag !== 1'b1) begin
         fails++; $display("FAIL sat_last_beat: got sum=%h err=%b expected 00008/1", s_sum, s_err_flag);
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_valid = 1'b1; a = 16'h0003; b = 16'h0004; approx_k = 4'd0; carry_mode = 1'b0;
      tick();
      a = 16'h0005; b = 16'h0006;
      tick();
      in_valid = 1'b0;
      tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         fails++; $display("FAIL rstmid_full: got valid=%b ready=%b expected 1/0", out_valid, in_ready);
      end
      rst = 1'b1;
      #1;
      tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 17'h0) begin
         fails++; $display("FAIL rstmid_flush: got valid=%b ready=%b sum=%h expected 0/1/0", out_valid, in_ready, sum);
      end
      tests++; if (sample_count !== 16'd0 || err_count !== 16'd0 || abs_err_sum !== 24'd0) begin
         fails++; $display("FAIL rstmid_stats: got %0d/%0d/%0d expected 0/0/0", sample_count, err_count, abs_err_sum);
      end
      tick();
      rst = 1'b0;
      tick();
      run_single("post_rst", 16'h00FF, 16'h0001, 4'd4, 1'b0, 17'h000FF, 1'b1);
      tests++; if (sample_count !== 16'd1 || abs_err_sum !== 24'd1) begin
         fails++; $display("FAIL post_rst_stats: got %0d/%0d expected 1/1", sample_count, abs_err_sum);
      end
   endtask

   task automatic test_random();
      logic [16:0] q_sum [$];
      logic        q_err [$];
      logic [16:0] e_sum;
      logic        e_err;
      logic        hold;
      int          n_acc;
      int          n_dlv;
      hold = 1'b0; n_acc = 0; n_dlv = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!hold) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            a          = 16'($urandom);
            b          = 16'($urandom);
            approx_k   = 4'($urandom_range(0, 15));
            carry_mode = 1'($urandom_range(0, 1));
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (in_valid && in_ready) begin
            e_sum = ref_sum(a, b, int'(approx_k), carry_mode);
            q_sum.push_back(e_sum);
            q_err.push_back(e_sum != ({1'b0, a} + {1'b0, b}));
            n_acc++;
         end
         hold = in_valid && !in_ready;
         if (out_valid && out_ready) begin
            n_dlv++;
            tests++;
            if (q_sum.size() == 0) begin
               fails++; $display("FAIL rnd_extra_beat: got sum=%h expected no output", sum);
            end else begin
               e_sum = q_sum.pop_front();
               e_err = q_err.pop_front();
               if (sum !== e_sum || err_flag !== e_err) begin
                  fails++; $display("FAIL rnd_beat_%0d: got sum=%h err=%b expected %h/%b", n_dlv, sum, err_flag, e_sum, e_err);
               end
            end
         end
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (out_valid) begin
            n_dlv++;
            tests++;
            if (q_sum.size() == 0) begin
               fails++; $display("FAIL rnd_drain_extra: got sum=%h expected no output", sum);
            end else begin
               e_sum = q_sum.pop_front();
               e_err = q_err.pop_front();
               if (sum !== e_sum || err_flag !== e_err) begin
                  fails++; $display("FAIL rnd_drain_%0d: got sum=%h err=%b expected %h/%b", n_dlv, sum, err_flag, e_sum, e_err);
               end
            end
         end
         tick();
      end
      tests++; if (n_dlv != n_acc || q_sum.size() != 0) begin
         fails++; $display("FAIL rnd_count: got delivered=%0d expected %0d", n_dlv, n_acc);
      end
   endtask

   initial begin
      test_reset();
      test_operation();
      test_backpressure();
      test_back_to_back();
      test_clr_stats();
      test_saturation();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/oloca_pipe.md
# oloca_pipe

Parametrised, pipelined successor to the 8-bit combinational OLOCA adder. It adds two WIDTH-bit operands with a runtime-selectable approximation depth k and carry mode, behind a valid/ready stream interface with full throughput and backpressure. A built-in error monitor computes the exact sum alongside the approximate one and keeps saturating error statistics for characterisation runs.

## Interface
- WIDTH, 16: operand width; WIDTH ≥ 2.
- MAX_APPROX, 8: largest approximation depth; 1 ≤ MAX_APPROX ≤ WIDTH-1.
- CNT_W, 16: width of the sample and error counters.
- ERR_W, 24: width of the absolute-error accumulator.
- KW (localparam): $clog2(MAX_APPROX+1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat when in_valid & in_ready.
- a, b  in  WIDTH  operands.
- approx_k  in  KW  approximation depth for this beat; values > MAX_APPROX clamp to MAX_APPROX.
- carry_mode  in  1  0: constant carry 0; 1: predicted carry a[k-1]&b[k-1].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result when out_valid & out_ready.
- sum  out  WIDTH+1  approximate sum.
- err_flag  out  1  sum differs from the exact sum; same beat as sum.
- clr_stats  in  1  synchronous clear of all statistics.
- sample_count  out  CNT_W  results delivered (handshaken).
- err_count  out  CNT_W  delivered results with err_flag=1.
- abs_err_sum  out  ERR_W  accumulated |exact - sum| over delivered results.

## Operation
- Per beat, k = min(approx_k, MAX_APPROX); k and carry_mode are captured with the operands, so changes affect only later beats.
- If k = 0: sum = a + b (exact), carry 0.
- If k > 0: sum[k-1:0] = a[k-1:0] | b[k-1:0]; sum[WIDTH:k] = a[WIDTH-1:k] + b[WIDTH-1:k] + c, where c = carry_mode ? (a[k-1] & b[k-1]) : 0. The upper add is WIDTH-k+1 bits wide with no truncation.
- exact = a + b (WIDTH+1 bits). abs_err = |exact - sum|, which is < 2^MAX_APPROX. err_flag = (abs_err != 0).
- Two pipeline stages:
  - S1 registers operands, clamped k and mode.
  - S2 registers sum, err_flag and abs_err.
- Flow control:
  - S2 advances when !s2_valid | out_ready.
  - S1 advances when it is empty or S2 advances.
  - in_ready = !s1_valid | s2_adv. No combinational path from in_valid to in_ready.
- While out_valid=1 and out_ready=0, sum and err_flag hold stable.
- Statistics update only on an output handshake:
  - sample_count += 1.
  - err_count += err_flag.
  - abs_err_sum += abs_err.
  - Each counter saturates at its all-ones value; counters are independent.
- clr_stats=1 zeroes all three counters next edge and takes priority over a same-cycle update; that sample is not counted. The data pipeline is unaffected by clr_stats.

## Timing
- Reset values:
  - All pipeline valids 0, so out_valid=0.
  - sum=0, err_flag=0, all statistics 0.
  - in_ready=1 once the pipeline is empty (combinationally 1 during reset).
- Reset mid-operation discards all in-flight beats; no partial statistics update.
- Latency: a beat accepted at edge n produces out_valid=1 after edge n+1 when unstalled.
- Throughput: 1 beat/cycle with out_ready held high.
- Capacity: 2 beats. With out_ready=0 the block accepts at most 2 beats, then in_ready=0.
- Simultaneous accept and deliver on a full pipeline is allowed; no bubble.

## Test plan
- WIDTH=16, MAX_APPROX=8. a=0x00FF, b=0x0001, k=4, mode 0 → sum=0x00FF, err_flag=1, abs_err=1, two cycles after accept.
- a=0x0008, b=0x0008, k=4 → mode 1: sum=0x0018, abs_err=8; mode 0: sum=0x0008, abs_err=8. a=0xFFFF, b=0x0001, k=0 → sum=0x10000, err_flag=0. approx_k=12 behaves as k=8.
- Backpressure: out_ready=0, offer 3 beats → 2 accepted, in_ready=0, sum stable. Raise out_ready → results delivered in order, one per cycle, then the third beat is accepted.
- Statistics: deliver the four first-scenario beats (errors 1, 8, 8, 0) → sample_count=4, err_count=3, abs_err_sum=17. Pulse clr_stats on a handshake cycle → all 0 and that beat is not counted. Preload to saturation (CNT_W=4) → counters hold at 15.
- Assert rst with 2 beats in flight → out_valid=0 immediately and all statistics 0. After release, a new beat completes normally with latency 2.
- Random stream with random valid/ready and k: scoreboard against the reference formula; no beat lost, duplicated or reordered.
